// File: rtl/epmp_pkg.sv
// Shared EPMP definitions: sequencer state encoding, opcode classes, ALU commands
// and the decoded-instruction payload.
package epmp_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CMD_W  = 4;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_FETCH_OP = 3'd2,
        ST_OPERAND  = 3'd3,
        ST_EXEC     = 3'd4,
        ST_HALT     = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU_IMM = 2'b00,
        CLS_ALU_IMP = 2'b01,
        CLS_MEM     = 2'b10,
        CLS_FLOW    = 2'b11
    } op_class_e;

    typedef enum logic [CMD_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_CLR  = 4'd2,
        ALU_NEG  = 4'd3,
        ALU_INR  = 4'd4,
        ALU_DCR  = 4'd5,
        ALU_AND  = 4'd6,
        ALU_OR   = 4'd7,
        ALU_LOAD = 4'd8
    } alu_cmd_e;

    typedef enum logic [3:0] {
        ACT_NOP     = 4'd0,
        ACT_ALU_IMM = 4'd1,
        ACT_ALU_IMP = 4'd2,
        ACT_STA     = 4'd3,
        ACT_ALU_MEM = 4'd4,
        ACT_JMP     = 4'd5,
        ACT_JC      = 4'd6,
        ACT_JNC     = 4'd7,
        ACT_HALT    = 4'd8
    } action_e;

    typedef struct packed {
        op_class_e cls;
        logic      needs_operand;
        logic      alu_valid;
        action_e   action;
    } decode_t;

    // True for ALU commands ADD through LOAD; higher codes decode as NOP.
    function automatic logic alu_cmd_valid(input logic [CMD_W-1:0] cmd);
        return cmd <= CMD_W'(ALU_LOAD);
    endfunction

endpackage

// File: rtl/epmp_control_if.sv
// Sequencer-side ROM / ALU / data-memory control bundle; the shared data bus
// stays a plain inout port on the sequencer.
interface epmp_control_if;
    import epmp_pkg::*;

    logic [ADDR_W-1:0] Prog_Addr;
    logic [DATA_W-1:0] Prog_Data;
    logic [ADDR_W-1:0] Mem_Addr;
    logic              Mem_Rd;
    logic              Mem_Wr;
    logic              ALU_En;
    logic [CMD_W-1:0]  ALU_Cmd;
    logic              ACC_Out_En;
    logic              C;
    logic              Halted;

    modport master (
        output Prog_Addr, Mem_Addr, Mem_Rd, Mem_Wr, ALU_En, ALU_Cmd, ACC_Out_En, Halted,
        input  Prog_Data, C
    );

    modport slave (
        input  Prog_Addr, Mem_Addr, Mem_Rd, Mem_Wr, ALU_En, ALU_Cmd, ACC_Out_En, Halted,
        output Prog_Data, C
    );

endinterface

// File: rtl/epmp_decode.sv
// Combinational opcode decoder: IR -> class, operand need, ALU command validity
// and the EXEC action (invalid ALU commands collapse to NOP).
module epmp_decode
    import epmp_pkg::*;
(
    input  logic [DATA_W-1:0] ir,
    output decode_t           dec
);

    op_class_e cls;
    logic      valid;

    assign cls   = op_class_e'(ir[7:6]);
    assign valid = alu_cmd_valid(ir[CMD_W-1:0]);

    always_comb begin
        dec               = '0;
        dec.cls           = cls;
        dec.alu_valid     = valid;
        dec.needs_operand = 1'b1;
        dec.action        = ACT_NOP;
        case (cls)
            CLS_ALU_IMM: dec.action = valid ? ACT_ALU_IMM : ACT_NOP;
            CLS_ALU_IMP: begin
                dec.needs_operand = 1'b0;
                dec.action        = valid ? ACT_ALU_IMP : ACT_NOP;
            end
            CLS_MEM: begin
                case (ir[5:4])
                    2'b00:   dec.action = ACT_STA;
                    2'b01:   dec.action = valid ? ACT_ALU_MEM : ACT_NOP;
                    default: dec.action = ACT_NOP;
                endcase
            end
            default: begin
                case (ir[1:0])
                    2'b00: dec.action = ACT_JMP;
                    2'b01: dec.action = ACT_JC;
                    2'b10: dec.action = ACT_JNC;
                    default: begin
                        dec.action        = ACT_HALT;
                        dec.needs_operand = 1'b0;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/epmp_control.sv
// EPMP instruction sequencer: fetch/decode/execute FSM driving the ALU, data bus
// and memory strobes. Optional single-step gating via EPMP_SINGLE_STEP_EN.
module epmp_control
    import epmp_pkg::*;
(
    input  logic              clk,
    input  logic              Reset,
`ifdef EPMP_SINGLE_STEP_EN
    input  logic              Step,
`endif
    epmp_control_if.master    bus,
    inout  wire  [DATA_W-1:0] Data_bus
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]  opr_q, opr_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               alu_en_q, alu_en_d;
    logic [CMD_W-1:0]   alu_cmd_q, alu_cmd_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_wr_q, mem_wr_d;
    logic               acc_oe_q, acc_oe_d;
    logic               drv_q, drv_d;
    logic               halted_q, halted_d;
    logic               exec_d;
    logic               step_go;
    decode_t            dec;

`ifdef EPMP_SINGLE_STEP_EN
    logic step_sync_q, step_sync_d;
    logic step_prev_q, step_prev_d;

    assign step_sync_d = Step;
    assign step_prev_d = step_sync_q;
    assign step_go     = step_sync_q & ~step_prev_q;
`else
    assign step_go = 1'b1;
`endif

    // IR/OPR capture the ROM byte presented the cycle after its address.
    assign ir_d       = (state_q == ST_DECODE)  ? bus.Prog_Data : ir_q;
    assign opr_d      = (state_q == ST_OPERAND) ? bus.Prog_Data : opr_q;
    assign mem_addr_d = opr_d;
    assign halted_d   = (state_d == ST_HALT);

    epmp_decode u_decode (
        .ir  (ir_d),
        .dec (dec)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        exec_d    = 1'b0;
        alu_en_d  = 1'b0;
        alu_cmd_d = '0;
        mem_rd_d  = 1'b0;
        mem_wr_d  = 1'b0;
        acc_oe_d  = 1'b0;
        drv_d     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (step_go) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                pc_d = pc_q + ADDR_W'(1);
                if (dec.action == ACT_HALT) begin
                    state_d = ST_HALT;
                end else if (dec.needs_operand) begin
                    state_d = ST_FETCH_OP;
                end else begin
                    state_d = ST_EXEC;
                    exec_d  = 1'b1;
                end
            end
            ST_FETCH_OP: state_d = ST_OPERAND;
            ST_OPERAND: begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = ST_EXEC;
                exec_d  = 1'b1;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (dec.action)
                    ACT_JMP: pc_d = opr_q;
                    ACT_JC:  if (bus.C)  pc_d = opr_q;
                    ACT_JNC: if (!bus.C) pc_d = opr_q;
                    default: ;
                endcase
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase

        // Strobes are registered on entry to EXEC so they live exactly one cycle.
        if (exec_d) begin
            alu_en_d  = dec.alu_valid &&
                        (dec.action inside {ACT_ALU_IMM, ACT_ALU_IMP, ACT_ALU_MEM});
            alu_cmd_d = alu_en_d ? ir_d[CMD_W-1:0] : '0;
            mem_rd_d  = (dec.action == ACT_ALU_MEM);
            mem_wr_d  = (dec.action == ACT_STA);
            acc_oe_d  = (dec.action == ACT_STA);
            drv_d     = (dec.cls == CLS_ALU_IMM) && dec.alu_valid;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            opr_q       <= '0;
            mem_addr_q  <= '0;
            alu_en_q    <= 1'b0;
            alu_cmd_q   <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            acc_oe_q    <= 1'b0;
            drv_q       <= 1'b0;
            halted_q    <= 1'b0;
`ifdef EPMP_SINGLE_STEP_EN
            step_sync_q <= 1'b0;
            step_prev_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            opr_q       <= opr_d;
            mem_addr_q  <= mem_addr_d;
            alu_en_q    <= alu_en_d;
            alu_cmd_q   <= alu_cmd_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            acc_oe_q    <= acc_oe_d;
            drv_q       <= drv_d;
            halted_q    <= halted_d;
`ifdef EPMP_SINGLE_STEP_EN
            step_sync_q <= step_sync_d;
            step_prev_q <= step_prev_d;
`endif
        end
    end

    assign bus.Prog_Addr  = pc_q;
    assign bus.Mem_Addr   = mem_addr_q;
    assign bus.Mem_Rd     = mem_rd_q;
    assign bus.Mem_Wr     = mem_wr_q;
    assign bus.ALU_En     = alu_en_q;
    assign bus.ALU_Cmd    = alu_cmd_q;
    assign bus.ACC_Out_En = acc_oe_q;
    assign bus.Halted     = halted_q;
    assign Data_bus       = drv_q ? opr_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_epmp_control.sv
// Bench for epmp_control: ROM/data-memory/ALU environment plus an
// instruction-level reference interpreter; directed programs then random ones.
module tb_epmp_control;
    import epmp_pkg::*;

    logic clk   = 1'b0;
    logic Reset = 1'b1;
`ifdef EPMP_SINGLE_STEP_EN
    logic Step  = 1'b0;
`endif
    wire [7:0] data_bus;

    epmp_control_if bus_if();

    epmp_control dut (
        .clk      (clk),
        .Reset    (Reset),
`ifdef EPMP_SINGLE_STEP_EN
        .Step     (Step),
`endif
        .bus      (bus_if),
        .Data_bus (data_bus)
    );

    always #5 clk = ~clk;

    logic [7:0] rom      [256];
    logic [7:0] dmem_img [256];
    logic [7:0] dmem     [256];
    logic [7:0] acc_env;
    logic       c_env;

    logic [7:0] m_pc, m_acc;
    logic       m_c;
    logic [7:0] m_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    // Returns {carry, result} of one ALU command.
    function automatic logic [8:0] alu_f(input logic [3:0] cmd, input logic [7:0] a,
                                         input logic [7:0] b, input logic ci);
        logic [8:0] r;
        r = {ci, a};
        case (cmd)
            4'd0: r = {1'b0, a} + {1'b0, b};
            4'd1: r = {a < b, 8'(a - b)};
            4'd2: r = 9'h000;
            4'd3: r = {a != 8'h00, 8'(8'h00 - a)};
            4'd4: r = {a == 8'hFF, 8'(a + 8'd1)};
            4'd5: r = {a == 8'h00, 8'(a - 8'd1)};
            4'd6: r = {ci, a & b};
            4'd7: r = {ci, a | b};
            4'd8: r = {ci, b};
            default: r = {ci, a};
        endcase
        return r;
    endfunction

    // Environment: synchronous ROM, data memory and accumulator ALU.
    assign bus_if.C = c_env;
    assign data_bus = bus_if.Mem_Rd ? dmem[bus_if.Mem_Addr] :
                      (bus_if.ACC_Out_En ? acc_env : 8'hzz);

    always @(posedge clk) begin
        bus_if.Prog_Data <= rom[bus_if.Prog_Addr];
        if (Reset) begin
            acc_env <= 8'h00;
            c_env   <= 1'b0;
            dmem    <= dmem_img;
        end else begin
            if (bus_if.ALU_En) {c_env, acc_env} <= alu_f(bus_if.ALU_Cmd, acc_env, data_bus, c_env);
            if (bus_if.Mem_Wr) dmem[bus_if.Mem_Addr] <= data_bus;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {bus_if.ALU_En, bus_if.Mem_Rd, bus_if.Mem_Wr, bus_if.ACC_Out_En};
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_prog_addr"}, 32'(bus_if.Prog_Addr), 32'h0);
        chk({tag, "_mem_addr"},  32'(bus_if.Mem_Addr),  32'h0);
        chk({tag, "_strobes"},   32'(strobes()),        32'h0);
        chk({tag, "_alu_cmd"},   32'(bus_if.ALU_Cmd),   32'h0);
        chk({tag, "_halted"},    32'(bus_if.Halted),    32'h0);
    endtask

    task automatic clear_images();
        for (int i = 0; i < 256; i++) begin
            rom[i]      = 8'hC3;
            dmem_img[i] = 8'h00;
        end
    endtask

    // Leaves the bench at the sampling point of the first FETCH cycle.
    task automatic do_reset(input string tag);
        Reset = 1'b1;
        m_pc  = 8'h00;
        m_acc = 8'h00;
        m_c   = 1'b0;
        for (int i = 0; i < 256; i++) m_mem[i] = dmem_img[i];
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs({tag, "_in_reset"});
        Reset = 1'b0;
        @(negedge clk);
    endtask

    // Executes one instruction of the reference interpreter and checks the DUT's
    // cycle-by-cycle behaviour for it; starts and ends at a FETCH sample.
    task automatic run_instr(output bit halted_o);
        logic [7:0] op, opd, nxt;
        logic [3:0] e_strb, e_cmd;
        logic       e_drv, has_opd, valid, quiet;
        int         n;
        op       = rom[m_pc];
        opd      = rom[8'(m_pc + 8'd1)];
        valid    = (op[3:0] <= 4'd8);
        has_opd  = !((op[7:6] == 2'b01) || (op[7:6] == 2'b11 && op[1:0] == 2'b11));
        n        = has_opd ? 5 : 3;
        nxt      = has_opd ? 8'(m_pc + 8'd2) : 8'(m_pc + 8'd1);
        e_strb   = 4'b0000;
        e_cmd    = 4'd0;
        e_drv    = 1'b0;
        halted_o = 1'b0;
        case (op[7:6])
            2'b00: if (valid) begin
                e_strb = 4'b1000; e_cmd = op[3:0]; e_drv = 1'b1;
                {m_c, m_acc} = alu_f(op[3:0], m_acc, opd, m_c);
            end
            2'b01: if (valid) begin
                e_strb = 4'b1000; e_cmd = op[3:0];
                {m_c, m_acc} = alu_f(op[3:0], m_acc, 8'h00, m_c);
            end
            2'b10: begin
                if (op[5:4] == 2'b00) begin
                    e_strb = 4'b0011;
                    m_mem[opd] = m_acc;
                end else if (op[5:4] == 2'b01 && valid) begin
                    e_strb = 4'b1100; e_cmd = op[3:0];
                    {m_c, m_acc} = alu_f(op[3:0], m_acc, m_mem[opd], m_c);
                end
            end
            default: begin
                case (op[1:0])
                    2'b00:   nxt = opd;
                    2'b01:   if (m_c)  nxt = opd;
                    2'b10:   if (!m_c) nxt = opd;
                    default: halted_o = 1'b1;
                endcase
            end
        endcase

        chk("fetch_addr", 32'(bus_if.Prog_Addr), 32'(m_pc));
`ifdef EPMP_SINGLE_STEP_EN
        Step = 1'b1;
        @(negedge clk);
        Step = 1'b0;
        chk("step_fetch_addr", 32'(bus_if.Prog_Addr), 32'(m_pc));
`endif
        quiet = 1'b1;
        for (int k = 2; k < n; k++) begin
            @(negedge clk);
            if (strobes() != 4'b0000 || bus_if.Halted) quiet = 1'b0;
        end
        @(negedge clk);
        chk("pre_exec_quiet", 32'(quiet), 32'h1);
        if (halted_o) begin
            chk("halt_flag",    32'(bus_if.Halted), 32'h1);
            chk("halt_strobes", 32'(strobes()),     32'h0);
        end else begin
            chk("exec_strobes", 32'(strobes()),      32'(e_strb));
            chk("exec_cmd",     32'(bus_if.ALU_Cmd), 32'(e_cmd));
            if (e_strb[2] || e_strb[1]) chk("exec_mem_addr", 32'(bus_if.Mem_Addr), 32'(opd));
            if (e_drv) chk("exec_bus_imm", 32'(data_bus), 32'(opd));
            @(negedge clk);
        end
        m_pc = nxt;
    endtask

    function automatic logic [7:0] rand_op();
        logic [1:0] cls;
        logic [5:0] lo;
        int         k;
        cls = 2'($urandom_range(0, 3));
        lo  = 6'($urandom);
        // Implied ops avoid bus-reading commands, whose operand would be floating.
        if (cls == 2'b01) begin
            k = int'($urandom_range(0, 10));
            lo[3:0] = (k < 4) ? 4'(k + 2) : 4'(k + 5);
        end
        return {cls, lo};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        int mism;

        // ADD #5, ADD #3
        clear_images();
        rom[0] = 8'h00; rom[1] = 8'h05; rom[2] = 8'h00; rom[3] = 8'h03;
        do_reset("t1");
        check_reset_outputs("t1_first_fetch");
        run_instr(h);
        run_instr(h);
        chk("t1_acc", 32'(acc_env), 32'h08);

        // INR implied
        clear_images();
        rom[0] = 8'h44;
        do_reset("t2");
        run_instr(h);
        chk("t2_pc_after", 32'(bus_if.Prog_Addr), 32'h01);
        chk("t2_acc",      32'(acc_env),          32'h01);

        // LOAD-free ADD #5A then STA 0x20
        clear_images();
        rom[0] = 8'h00; rom[1] = 8'h5A; rom[2] = 8'h80; rom[3] = 8'h20;
        do_reset("t3");
        run_instr(h);
        run_instr(h);
        chk("t3_mem20", 32'(dmem[8'h20]), 32'h5A);

        // JC not taken, set carry, JC taken, HALT persists
        clear_images();
        rom[0] = 8'hC1; rom[1] = 8'h40;
        rom[2] = 8'h00; rom[3] = 8'hFF;
        rom[4] = 8'h00; rom[5] = 8'h01;
        rom[6] = 8'hC1; rom[7] = 8'h40;
        do_reset("t4");
        run_instr(h);
        chk("t4_jc_not_taken", 32'(bus_if.Prog_Addr), 32'h02);
        run_instr(h);
        run_instr(h);
        chk("t4_carry_set", 32'(c_env), 32'h1);
        run_instr(h);
        chk("t4_jc_taken", 32'(bus_if.Prog_Addr), 32'h40);
        run_instr(h);
        chk("t4_halt_reported", 32'(h), 32'h1);
        repeat (5) @(negedge clk);
        chk("t4_halt_hold",    32'(bus_if.Halted),    32'h1);
        chk("t4_halt_quiet",   32'(strobes()),        32'h0);
        chk("t4_halt_pc_hold", 32'(bus_if.Prog_Addr), 32'h41);

        // PC wrap, including operand fetch across 0xFF -> 0x00
        clear_images();
        rom[8'h00] = 8'hC0; rom[8'h01] = 8'hFE; rom[8'h02] = 8'h03;
        rom[8'hFE] = 8'h44; rom[8'hFF] = 8'h00;
        do_reset("t5");
        run_instr(h);
        chk("t5_jmp_fe", 32'(bus_if.Prog_Addr), 32'hFE);
        run_instr(h);
        chk("t5_pc_ff", 32'(bus_if.Prog_Addr), 32'hFF);
        run_instr(h);
        chk("t5_wrap_operand", 32'(bus_if.Prog_Addr), 32'h01);
        chk("t5_acc",          32'(acc_env),          32'hC1);
        run_instr(h);
        chk("t5_jnc_taken", 32'(bus_if.Prog_Addr), 32'h03);
        run_instr(h);
        chk("t5_halted", 32'(bus_if.Halted), 32'h1);

        // Asynchronous reset in the middle of an EXEC cycle
        clear_images();
        rom[0] = 8'h00; rom[1] = 8'h05;
        do_reset("t6");
`ifdef EPMP_SINGLE_STEP_EN
        Step = 1'b1;
        @(negedge clk);
        Step = 1'b0;
`endif
        repeat (4) @(negedge clk);
        chk("t6_in_exec", 32'(bus_if.ALU_En), 32'h1);
        #1 Reset = 1'b1;
        #1;
        check_reset_outputs("t6_async");

`ifdef EPMP_SINGLE_STEP_EN
        // Without Step edges the sequencer must stay in FETCH.
        clear_images();
        rom[0] = 8'h44;
        do_reset("t7");
        begin
            bit idle_ok;
            idle_ok = 1'b1;
            repeat (20) begin
                @(negedge clk);
                if (bus_if.Prog_Addr != 8'h00 || strobes() != 4'b0000) idle_ok = 1'b0;
            end
            chk("t7_step_idle", 32'(idle_ok), 32'h1);
            run_instr(h);
            idle_ok = 1'b1;
            repeat (6) begin
                @(negedge clk);
                if (bus_if.Prog_Addr != 8'h01 || strobes() != 4'b0000) idle_ok = 1'b0;
            end
            chk("t7_one_instr", 32'(idle_ok), 32'h1);
        end
`endif

        // Random programs against the interpreter
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 256; i++) begin
                rom[i]      = rand_op();
                dmem_img[i] = 8'($urandom);
            end
            do_reset("rnd");
            h = 1'b0;
            for (int s = 0; s < 30 && !h; s++) run_instr(h);
            if (!h) @(negedge clk);
            chk("rnd_acc",   32'(acc_env), 32'(m_acc));
            chk("rnd_carry", 32'(c_env),   32'(m_c));
            mism = 0;
            for (int i = 0; i < 256; i++) if (dmem[i] !== m_mem[i]) mism++;
            chk("rnd_dmem_mismatches", 32'(mism), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
